// File: rtl/prog_counter.sv
// prog_counter
// Programmable up/down counter with parallel load, terminal value, clock-enable
// prescaler and wrap / saturate / one-shot end-of-count handling.
// All outputs are registered; every state update happens on the rising clock edge.

module prog_counter #(
   parameter int WIDTH      = 32,
   parameter int PRESCALE_W = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  up_down,
   input  logic                  load,
   input  logic [WIDTH-1:0]      load_value,
   input  logic [WIDTH-1:0]      limit,
   input  logic [1:0]            mode,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic [WIDTH-1:0]      count,
   output logic                  tc,
   output logic                  done
);

   localparam logic [1:0] MODE_SAT     = 2'b01;
   localparam logic [1:0] MODE_ONESHOT = 2'b10;

   logic [WIDTH-1:0]      count_q,   count_d;
   logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
   logic                  tc_q,      tc_d;
   logic                  done_q,    done_d;
   logic                  tick;
   logic                  at_term;

   // Tick and terminal condition come straight from live inputs, nothing latched.
   always_comb begin
      tick    = enable && (pre_cnt_q == prescale);
      at_term = up_down ? (count_q >= limit) : (count_q == '0);
   end

   // Next-state: load beats tick; a finished one-shot ignores ticks but the
   // prescaler keeps its phase running.
   always_comb begin
      count_d   = count_q;
      pre_cnt_d = pre_cnt_q;
      tc_d      = 1'b0;
      done_d    = done_q;
      if (load) begin
         count_d   = load_value;
         pre_cnt_d = '0;
         done_d    = 1'b0;
      end else begin
         if (tick) begin
            pre_cnt_d = '0;
         end else if (enable) begin
            pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
         end
         if (tick && !done_q) begin
            if (!at_term) begin
               count_d = up_down ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
            end else begin
               tc_d = 1'b1;
               case (mode)
                  MODE_SAT:     count_d = count_q;
                  MODE_ONESHOT: done_d  = 1'b1;
                  default:      count_d = up_down ? '0 : limit;
               endcase
            end
         end
      end
   end

   // State registers with synchronous reset taking priority over everything.
   always_ff @(posedge clock) begin
      if (reset) begin
         count_q   <= '0;
         pre_cnt_q <= '0;
         tc_q      <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         count_q   <= count_d;
         pre_cnt_q <= pre_cnt_d;
         tc_q      <= tc_d;
         done_q    <= done_d;
      end
   end

   assign count = count_q;
   assign tc    = tc_q;
   assign done  = done_q;

endmodule

// File: tb/tb_prog_counter.sv
// Self-checking bench for prog_counter (WIDTH=8, PRESCALE_W=4): a vector table,
// hand-written corner sequences and a randomized run against a reference model.

module tb_prog_counter;

   localparam int W  = 8;
   localparam int PW = 4;
   localparam int CMOD = 1 << W;
   localparam int PMOD = 1 << PW;

   logic          clock = 1'b0;
   logic          reset, enable, up_down, load;
   logic [W-1:0]  load_value, limit;
   logic [1:0]    mode;
   logic [PW-1:0] prescale;
   logic [W-1:0]  count;
   logic          tc, done;

   int n_total = 0;
   int n_pass  = 0;

   // reference model state
   int m_count = 0;
   int m_pre   = 0;
   bit m_tc    = 0;
   bit m_done  = 0;

   prog_counter #(.WIDTH(W), .PRESCALE_W(PW)) dut (
      .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
      .load(load), .load_value(load_value), .limit(limit), .mode(mode),
      .prescale(prescale), .count(count), .tc(tc), .done(done)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic          rst, ld, en, ud;
      logic [1:0]    md;
      logic [PW-1:0] ps;
      logic [W-1:0]  lim, lv;
      int            e_cnt;
      logic          e_tc, e_done;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic expect3(input string nm, input int c, input int t, input int d);
      chk({nm, " count"}, int'(count), c);
      chk({nm, " tc"},    int'(tc),    t);
      chk({nm, " done"},  int'(done),  d);
   endtask

   task automatic set_in(input logic rst, input logic ld, input logic en, input logic ud,
                         input logic [1:0] md, input int ps, input int lim, input int lv);
      reset = rst; load = ld; enable = en; up_down = ud; mode = md;
      prescale = PW'(ps); limit = W'(lim); load_value = W'(lv);
   endtask

   // Reference behaviour written from the counter's rules with plain integers.
   task automatic model_step();
      bit tick, term;
      tick = enable && (m_pre == int'(prescale));
      term = up_down ? (m_count >= int'(limit)) : (m_count == 0);
      if (reset) begin
         m_count = 0; m_pre = 0; m_tc = 0; m_done = 0;
      end else if (load) begin
         m_count = int'(load_value); m_pre = 0; m_tc = 0; m_done = 0;
      end else begin
         m_tc = 0;
         if (tick) m_pre = 0;
         else if (enable) m_pre = (m_pre + 1) % PMOD;
         if (tick && !m_done) begin
            if (!term) m_count = up_down ? (m_count + 1) % CMOD : (m_count + CMOD - 1) % CMOD;
            else begin
               m_tc = 1;
               if (mode == 2'b10) m_done = 1;
               else if (mode != 2'b01) m_count = up_down ? 0 : int'(limit);
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clock);
      model_step();
      #1;
   endtask

   initial begin
      set_in(1, 0, 0, 1, 0, 0, 0, 0);
      #2;

      // test 1: wrap at limit=3, tc aligned with the 3->0 step
      tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4'd0, 8'd3, 8'd0, 0, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4'd0, 8'd3, 8'd0, 0, 1'b0, 1'b0};
      tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 4'd0, 8'd3, 8'd0, 1, 1'b0, 1'b0};
      tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 4'd0, 8'd3, 8'd0, 2, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 4'd0, 8'd3, 8'd0, 3, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 4'd0, 8'd3, 8'd0, 0, 1'b1, 1'b0};
      tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 4'd0, 8'd3, 8'd0, 1, 1'b0, 1'b0};
      tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 4'd0, 8'd3, 8'd0, 2, 1'b0, 1'b0};
      for (int i = 0; i < 8; i++) begin
         set_in(tbl[i].rst, tbl[i].ld, tbl[i].en, tbl[i].ud, tbl[i].md,
                int'(tbl[i].ps), int'(tbl[i].lim), int'(tbl[i].lv));
         step();
         expect3($sformatf("vec%0d", i), tbl[i].e_cnt, int'(tbl[i].e_tc), int'(tbl[i].e_done));
      end

      // test 2: prescale=2 and enable drop holds count and prescaler phase
      begin
         int exp2[6] = '{0, 0, 1, 1, 1, 2};
         set_in(1, 0, 0, 1, 0, 0, 0, 0); step();
         set_in(0, 0, 1, 1, 0, 2, 100, 0);
         for (int i = 0; i < 6; i++) begin step(); chk($sformatf("presc step%0d", i), int'(count), exp2[i]); end
         enable = 1'b0;
         for (int i = 0; i < 4; i++) begin step(); chk("presc hold", int'(count), 2); end
         enable = 1'b1;
         step(); chk("presc resume0", int'(count), 2);
         step(); chk("presc resume1", int'(count), 2);
         step(); chk("presc resume2", int'(count), 3);
      end

      // test 3: load 2, saturate down, then count up
      set_in(0, 1, 1, 0, 1, 0, 100, 2); step(); expect3("sat load", 2, 0, 0);
      load = 1'b0;
      step(); expect3("sat d1", 1, 0, 0);
      step(); expect3("sat d0", 0, 0, 0);
      step(); expect3("sat hold0", 0, 1, 0);
      step(); expect3("sat hold1", 0, 1, 0);
      up_down = 1'b1;
      step(); expect3("sat up1", 1, 0, 0);
      step(); expect3("sat up2", 2, 0, 0);

      // test 4: one-shot to 5, sticky done, single tc, load restarts
      set_in(0, 1, 1, 1, 2, 0, 5, 0); step(); expect3("os load", 0, 0, 0);
      load = 1'b0;
      for (int i = 1; i <= 5; i++) begin step(); expect3($sformatf("os up%0d", i), i, 0, 0); end
      step(); expect3("os end", 5, 1, 1);
      for (int i = 0; i < 10; i++) begin step(); expect3("os idle", 5, 0, 1); end
      mode = 2'b00;
      step(); expect3("os modechg", 5, 0, 1);
      step(); expect3("os modechg2", 5, 0, 1);
      mode = 2'b10; load = 1'b1; load_value = '0;
      step(); expect3("os reload", 0, 0, 0);
      load = 1'b0;
      step(); expect3("os resume", 1, 0, 0);

      // test 5: loaded value above limit wraps immediately; load beats tick
      set_in(0, 1, 1, 1, 0, 0, 200, 250); step(); expect3("above load", 250, 0, 0);
      load = 1'b0;
      step(); expect3("above wrap", 0, 1, 0);
      set_in(0, 1, 1, 1, 0, 0, 200, 77); step(); expect3("load vs tick", 77, 0, 0);

      // test 6: reset beats load mid-count and restarts the prescaler
      set_in(0, 1, 1, 1, 0, 3, 100, 7); step(); expect3("rst pre load", 7, 0, 0);
      load = 1'b0;
      step(); step(); chk("rst pre mid", int'(count), 7);
      set_in(1, 1, 1, 1, 0, 3, 100, 9); step(); expect3("rst vs load", 0, 0, 0);
      set_in(0, 0, 1, 1, 0, 3, 100, 9);
      step(); chk("rst pre0", int'(count), 0);
      step(); chk("rst pre1", int'(count), 0);
      step(); chk("rst pre2", int'(count), 0);
      step(); chk("rst pre3", int'(count), 1);

      // randomized run against the reference model
      set_in(1, 0, 0, 1, 0, 0, 10, 0); step();
      for (int i = 0; i < 1500; i++) begin
         reset   = ($urandom_range(0, 59) == 0);
         load    = ($urandom_range(0, 24) == 0);
         enable  = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 19) == 0) up_down = ~up_down;
         if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 39) == 0)
            prescale = ($urandom_range(0, 3) == 0) ? PW'($urandom_range(0, PMOD - 1))
                                                   : PW'($urandom_range(0, 2));
         if ($urandom_range(0, 29) == 0)
            limit = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, CMOD - 1))
                                                : W'($urandom_range(0, 12));
         load_value = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, CMOD - 1))
                                                  : W'($urandom_range(0, 15));
         step();
         chk("rnd count", int'(count), m_count);
         chk("rnd tc",    int'(tc),    int'(m_tc));
         chk("rnd done",  int'(done),  int'(m_done));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/prog_counter.md
Name: prog_counter

Overview:
Parametrised programmable counter. It replaces the fixed 32-bit free-running up counter.
- Adds configurable width, up/down direction, parallel load and a programmable terminal value (limit).
- Adds a clock-enable prescaler and three end-of-count modes: wrap, saturate and one-shot.
- Used as the general timer/event counter in the Module-1 datapath blocks.

Parameters:
WIDTH, 32, bit width of count, load_value and limit.
PRESCALE_W, 8, bit width of the prescale divider input.

Ports:
clock  input  1  single system clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high reset.
enable  input  1  count enable; gates the prescaler and the counting.
up_down  input  1  1 = count up, 0 = count down.
load  input  1  synchronous parallel load strobe.
load_value  input  WIDTH  value loaded into count when load=1.
limit  input  WIDTH  terminal value for up-counting and reload value for down-wrap.
mode  input  2  00 wrap, 01 saturate, 10 one-shot, 11 reserved (behaves as wrap).
prescale  input  PRESCALE_W  a tick occurs every prescale+1 enabled cycles.
count  output  WIDTH  current count (registered).
tc  output  1  terminal-count pulse (registered, one cycle wide).
done  output  1  one-shot completed flag (sticky).

Behaviour:
- Priority at each rising clock edge: reset > load > tick > hold.
- Reset:
  - count=0, tc=0, done=0.
  - Internal prescale counter pre_cnt=0.
  - Reset wins over load and enable when asserted together.
- Load (reset=0):
  - count=load_value, pre_cnt=0, done=0, tc=0.
  - Load is independent of enable. A tick in the same cycle is discarded.
- Prescaler:
  - pre_cnt has width PRESCALE_W.
  - tick = enable && (pre_cnt == prescale).
  - On a tick, pre_cnt returns to 0. Otherwise, if enable=1, pre_cnt increments. If enable=0, pre_cnt holds.
  - prescale=0 gives a tick on every enabled cycle.
  - A change to prescale takes effect on the next comparison. If pre_cnt > prescale after a change, pre_cnt counts on and wraps modulo 2^PRESCALE_W before it can match.
- Terminal condition, evaluated combinationally from the current count and limit:
  - up: count >= limit.
  - down: count == 0.
  - limit and up_down are sampled live, with no latching.
- On a tick with the terminal condition false: count +1 when up, count -1 when down.
- On a tick with the terminal condition true:
  - wrap (00, 11): up goes to 0; down goes to limit.
  - saturate (01): count holds.
  - one-shot (10): count holds and done is set to 1.
- tc:
  - tc=1 in the cycle after a tick on which the terminal condition was true; otherwise tc=0.
  - In saturate mode, tc pulses on every tick while at the boundary.
  - In one-shot mode, tc pulses once. While done=1, ticks are ignored: no count change, no tc. pre_cnt keeps running.
- done remains 1 until reset or load.
- A mode change while done=1 does not clear done.
- limit=0 when counting up: the terminal condition is true at count=0, so count stays 0 in wrap and saturate modes, and tc pulses on every tick.
- Arithmetic is modulo 2^WIDTH, with no carry out.
  - A loaded value above limit, counting up, reaches the terminal condition immediately. In wrap mode the next tick goes to 0.
- Latency: count updates on the edge of the tick cycle. tc is visible on that same edge, aligned with the count update.

Test Plan:
1. WIDTH=32, reset 2 cycles, then enable=1, up, mode=00, limit=3, prescale=0 -> count 0,1,2,3,0,1. tc=1 only in the cycle count shows 0 after 3.
2. prescale=2, enable=1, up, limit=100 -> count steps every 3rd cycle (0,0,0,1,1,1,2). Dropping enable for 4 cycles holds both count and the prescaler phase.
3. load=1 with load_value=2, then down, mode=01 -> count 2,1,0,0,0. tc pulses on each tick after reaching 0. Then up_down=1 -> 1,2.
4. mode=10, up, limit=5, start at 0 -> count stops at 5, done=1, exactly one tc pulse. Ten more ticks give no change. load_value=0 with load -> done=0 and counting resumes.
5. WIDTH=8, limit=8'd200, load_value=8'd250, up, wrap -> next tick count=0 with tc=1. Load and a tick in the same cycle -> count equals load_value.
6. Mid-count (count=7), assert reset together with load=1 and load_value=9 -> next edge count=0, tc=0, done=0, and the prescaler restarts from 0.
